// File: rtl/req_pending_capture.sv
// Request capture ahead of the 4-to-2 priority encoder: sync, edge, sticky pend.
// Optional glitch filter on the synchronized lines: define REQ_DEBOUNCE_EN.
module req_pending_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic       ack,
    input  logic [1:0] ack_idx,
    output logic [3:0] pend,
    output logic       any_pend,
    output logic [3:0] overrun,
    output logic       ack_err
);

    if (SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_bad_param
        $error("req_pending_capture: SYNC_STAGES>=2, DB_CYCLES>=1");
    end

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] s;
    logic [3:0] lvl;
    logic [3:0] lvl_d;
    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] pend_nxt;
    logic [3:0] ovr_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= req_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef REQ_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [CW-1:0] db_cnt [4];
    logic [3:0]    flt;

    // Any return to the filtered value restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt <= '0;
            for (int n = 0; n < 4; n++) begin
                db_cnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (s[n] == flt[n]) begin
                    db_cnt[n] <= '0;
                end else if (db_cnt[n] == CNT_MAX) begin
                    flt[n]    <= s[n];
                    db_cnt[n] <= '0;
                end else begin
                    db_cnt[n] <= db_cnt[n] + CW'(1);
                end
            end
        end
    end

    assign lvl = flt;
`else
    assign lvl = s;
`endif

    assign rise = lvl & ~lvl_d;

    always_comb begin
        clr = '0;
        unique case (ack_idx)
            2'd0: clr[0] = ack;
            2'd1: clr[1] = ack;
            2'd2: clr[2] = ack;
            2'd3: clr[3] = ack;
            default: clr = '0;
        endcase
    end

    // A fresh edge beats a coincident clear.
    always_comb begin
        pend_nxt = pend;
        for (int n = 0; n < 4; n++) begin
            unique case (1'b1)
                rise[n]:            pend_nxt[n] = 1'b1;
                !rise[n] && clr[n]: pend_nxt[n] = 1'b0;
                default:            pend_nxt[n] = pend[n];
            endcase
        end
    end

    assign ovr_set = rise & pend & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d    <= '0;
            pend     <= '0;
            any_pend <= 1'b0;
            overrun  <= '0;
            ack_err  <= 1'b0;
        end else begin
            lvl_d    <= lvl;
            pend     <= pend_nxt;
            any_pend <= |pend_nxt;
            overrun  <= overrun | ovr_set;
            ack_err  <= ack & ~pend[ack_idx];
        end
    end

endmodule

// File: tb/tb_req_pending_capture.sv
// Directed bench for req_pending_capture.
// Define REQ_DEBOUNCE_EN to match a debounced DUT build.
module tb_req_pending_capture;

    localparam int SYNC = 2;
    localparam int DB   = 4;
`ifdef REQ_DEBOUNCE_EN
    localparam int LAT = SYNC + DB + 1;
`else
    localparam int LAT = SYNC + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_in;
    logic       ack;
    logic [1:0] ack_idx;
    logic [3:0] pend;
    logic       any_pend;
    logic [3:0] overrun;
    logic       ack_err;

    int total = 0;
    int bad   = 0;

    req_pending_capture #(
        .SYNC_STAGES(SYNC),
        .DB_CYCLES  (DB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_in  (req_in),
        .ack     (ack),
        .ack_idx (ack_idx),
        .pend    (pend),
        .any_pend(any_pend),
        .overrun (overrun),
        .ack_err (ack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One rising edge on mask, then drop and let the line settle low.
    task automatic fire(input logic [3:0] m);
        req_in = m;
        repeat (LAT) tick();
        req_in = '0;
        repeat (LAT + 1) tick();
    endtask

    task automatic do_ack(input logic [1:0] idx);
        ack     = 1'b1;
        ack_idx = idx;
        tick();
        ack     = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        req_in  = '0;
        ack     = 1'b0;
        ack_idx = '0;
        repeat (3) tick();
        chk("rst_pend", {4'b0, pend}, 8'h00);
        chk("rst_any", {7'b0, any_pend}, 8'h00);
        chk("rst_ovr", {4'b0, overrun}, 8'h00);
        chk("rst_err", {7'b0, ack_err}, 8'h00);
        rst_n = 1'b1;
        repeat (2) tick();

        // basic capture and exact latency
        req_in = 4'b0100;
        repeat (LAT - 1) tick();
        chk("cap_early", {4'b0, pend}, 8'h00);
        tick();
        chk("cap_pend", {4'b0, pend}, 8'h04);
        chk("cap_any", {7'b0, any_pend}, 8'h01);
        chk("cap_ovr", {4'b0, overrun}, 8'h00);
        req_in = '0;
        repeat (LAT + 1) tick();
        chk("cap_hold", {4'b0, pend}, 8'h04);

        // acknowledge clears
        do_ack(2'd2);
        chk("clr2", {4'b0, pend}, 8'h00);
        chk("clr2_err", {7'b0, ack_err}, 8'h00);
        fire(4'b1010);
        chk("set_1010", {4'b0, pend}, 8'h0a);
        do_ack(2'd3);
        chk("ack3_pend", {4'b0, pend}, 8'h02);
        chk("ack3_err", {7'b0, ack_err}, 8'h00);
        do_ack(2'd1);
        chk("ack1_pend", {4'b0, pend}, 8'h00);
        chk("ack1_any", {7'b0, any_pend}, 8'h00);
        chk("ack1_err", {7'b0, ack_err}, 8'h00);

        // overrun on second edge
        fire(4'b0001);
        chk("ch0_pend", {4'b0, pend}, 8'h01);
        chk("ch0_ovr0", {4'b0, overrun}, 8'h00);
        fire(4'b0001);
        chk("ch0_ovr1", {4'b0, overrun}, 8'h01);
        chk("ch0_still", {4'b0, pend}, 8'h01);

        // edge and clear on channel 2 in the same cycle
        fire(4'b0100);
        chk("ch2_pend", {4'b0, pend}, 8'h05);
        req_in = 4'b0100;
        repeat (LAT - 1) tick();
        do_ack(2'd2);
        chk("coll_pend", {4'b0, pend}, 8'h05);
        chk("coll_ovr", {4'b0, overrun}, 8'h01);
        chk("coll_err", {7'b0, ack_err}, 8'h00);
        req_in = '0;
        repeat (LAT + 1) tick();

        // ack for a channel that is not pending
        do_ack(2'd0);
        do_ack(2'd2);
        chk("empty", {4'b0, pend}, 8'h00);
        do_ack(2'd2);
        chk("bad_err", {7'b0, ack_err}, 8'h01);
        chk("bad_pend", {4'b0, pend}, 8'h00);
        tick();
        chk("bad_err_1", {7'b0, ack_err}, 8'h00);

        // asynchronous reset mid-operation
        fire(4'b1111);
        fire(4'b0010);
        chk("pre_pend", {4'b0, pend}, 8'h0f);
        chk("pre_ovr", {4'b0, overrun}, 8'h03);
        req_in = 4'b1000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pend", {4'b0, pend}, 8'h00);
        chk("ar_any", {7'b0, any_pend}, 8'h00);
        chk("ar_ovr", {4'b0, overrun}, 8'h00);
        chk("ar_err", {7'b0, ack_err}, 8'h00);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (LAT - 1) tick();
        chk("rel_early", {4'b0, pend}, 8'h00);
        tick();
        chk("rel_pend", {4'b0, pend}, 8'h08);
        repeat (4) tick();
        do_ack(2'd3);
        repeat (3) tick();
        chk("rel_once", {4'b0, pend}, 8'h00);
        req_in = '0;
        repeat (LAT + 1) tick();

`ifdef REQ_DEBOUNCE_EN
        // short glitch is filtered, long level passes
        req_in = 4'b0010;
        repeat (3) tick();
        req_in = '0;
        repeat (12) tick();
        chk("db_short", {4'b0, pend}, 8'h00);
        req_in = 4'b0010;
        repeat (6) tick();
        chk("db_early", {4'b0, pend}, 8'h00);
        req_in = '0;
        tick();
        chk("db_long", {4'b0, pend}, 8'h02);
        repeat (12) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
